// File: rtl/edge_mem_pkg.sv
// Shared definitions for the edge memory pipeline: FSM encoding, default clear
// word and the read-latency legality check.
package edge_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [63:0] DEFAULT_CLEAR_VAL = 64'd0;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/edge_memory_pipe_sdp_ram.sv
// Inferred simple-dual-port array: one write port, one read port with a
// registered, read-first output. No reset so it maps onto block RAM.
module sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_reg;

  // Read-first: a same-address write in the read cycle is not visible here;
  // the caller forwards it when it needs new data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/edge_memory_pipe.sv
// Edge storage with configurable read latency, same-cycle write forwarding and
// a clear sequencer that sweeps CLEAR_VAL over the array after reset or on demand.
module edge_memory_pipe
  import edge_mem_pkg::*;
#(
  parameter int                ADDR_W         = 10,
  parameter int                DATA_W         = 36,
  parameter int                RD_LAT         = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = DATA_W'(DEFAULT_CLEAR_VAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic              wren,
  input  logic [DATA_W-1:0] wrdata,
  input  logic [ADDR_W-1:0] rdaddr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("edge_memory_pipe: RD_LAT must be 1 or 2");
  end

  state_t            state_reg;
  logic              busy_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              cnt_last;

  logic              in_clear;
  logic              ext_wr;
  logic              rd_acc;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              fwd_hit_reg;
  logic [DATA_W-1:0] fwd_data_reg;
  logic [DATA_W-1:0] stage1_data;

  assign cnt_last = &cnt_reg;
  assign in_clear = (state_reg == ST_CLEAR);
  assign ext_wr   = (state_reg == ST_IDLE) && wren;
  assign rd_acc   = (state_reg == ST_IDLE) && rd_en && !rst;

  // Clear sequencer; the counter stops at the last address, no wrap re-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      busy_reg  <= (CLEAR_ON_RESET != 0);
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clear) begin
            state_reg <= ST_CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        ST_CLEAR: begin
          cnt_reg <= cnt_reg + ADDR_W'(1);
          if (cnt_last) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  // The clear sweep owns the write port whenever it runs.
  assign ram_we    = !rst && (in_clear || ext_wr);
  assign ram_waddr = in_clear ? cnt_reg : wraddr;
  assign ram_wdata = in_clear ? CLEAR_VAL : wrdata;

  sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_acc),
    .raddr (rdaddr),
    .rdata (ram_rdata)
  );

  // Forwarding state only moves on an accepted read, so together with the
  // enabled RAM read register the stage-1 word holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else if (rd_acc) begin
      fwd_hit_reg  <= ext_wr && (wraddr == rdaddr);
      fwd_data_reg <= wrdata;
    end
  end

  assign stage1_data = fwd_hit_reg ? fwd_data_reg : ram_rdata;

  if (RD_LAT == 1) begin : g_lat1
    logic vld_reg;
    logic q_live_reg;

    // q_live_reg masks the unreset RAM register until a read has landed.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg    <= 1'b0;
        q_live_reg <= 1'b0;
      end else begin
        vld_reg <= rd_acc;
        if (rd_acc) begin
          q_live_reg <= 1'b1;
        end
      end
    end

    assign q       = q_live_reg ? stage1_data : '0;
    assign q_valid = vld_reg;
  end else begin : g_lat2
    logic [1:0]        vld_reg;
    logic [DATA_W-1:0] out_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg <= 2'b00;
        out_reg <= '0;
      end else begin
        vld_reg <= {vld_reg[0], rd_acc};
        if (vld_reg[0]) begin
          out_reg <= stage1_data;
        end
      end
    end

    assign q       = out_reg;
    assign q_valid = vld_reg[1];
  end

endmodule

// File: tb/tb_edge_memory_pipe.sv
// Directed bench for edge_memory_pipe: two instances (RD_LAT=1 and RD_LAT=2)
// share stimulus; a two-stage expectation pipe tracks q/q_valid every cycle.
module tb_edge_memory_pipe;

  localparam int AW = 4;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rst, clear, wren, rd_en;
  logic [AW-1:0] wraddr, rdaddr;
  logic [DW-1:0] wrdata;
  logic          busy1, busy2, qv1, qv2;
  logic [DW-1:0] q1, q2;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectation pipes: lat1 output one cycle after issue, lat2 after two.
  logic          issue_v;
  logic [DW-1:0] issue_d;
  logic          p1v;
  logic [DW-1:0] p1d;
  logic [1:0]    p2v;
  logic [DW-1:0] p2d [2];
  logic [DW-1:0] eq1, eq2;

  always #5 clk = ~clk;

  edge_memory_pipe #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CLEAR_ON_RESET(1), .CLEAR_VAL(36'h0)
  ) dut_lat1 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy1),
    .wraddr(wraddr), .wren(wren), .wrdata(wrdata),
    .rdaddr(rdaddr), .rd_en(rd_en), .q(q1), .q_valid(qv1)
  );

  edge_memory_pipe #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CLEAR_ON_RESET(1), .CLEAR_VAL(36'h0)
  ) dut_lat2 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy2),
    .wraddr(wraddr), .wren(wren), .wrdata(wrdata),
    .rdaddr(rdaddr), .rd_en(rd_en), .q(q2), .q_valid(qv2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      p1v = 1'b0;
      p2v = 2'b00;
      eq1 = '0;
      eq2 = '0;
    end else begin
      p2v[1] = p2v[0];
      p2d[1] = p2d[0];
      p2v[0] = issue_v;
      p2d[0] = issue_d;
      p1v    = issue_v;
      p1d    = issue_d;
    end
    issue_v = 1'b0;
    #1;
    if (p1v)    eq1 = p1d;
    if (p2v[1]) eq2 = p2d[1];
    check("qvalid_lat1", 64'(qv1), 64'(p1v));
    check("q_lat1",      64'(q1),  64'(eq1));
    check("qvalid_lat2", 64'(qv2), 64'(p2v[1]));
    check("q_lat2",      64'(q2),  64'(eq2));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    $display("[%0t] write addr=%0d data=%h", $time, a, d);
    wren = 1'b1; wraddr = a; wrdata = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    $display("[%0t] read  addr=%0d expect=%h", $time, a, e);
    rd_en = 1'b1; rdaddr = a; issue_v = 1'b1; issue_d = e;
    tick();
    rd_en = 1'b0;
  endtask

  // Runs while either instance is busy, hammering the ignored ports.
  task automatic busy_run(output int n1, output int n2);
    n1 = 0;
    n2 = 0;
    for (int g = 0; g < 40 && (busy1 || busy2); g++) begin
      wren = 1'b1; wraddr = AW'(g); wrdata = 36'hBAD;
      rd_en = 1'b1; rdaddr = AW'(g);
      if (busy1) n1++;
      if (busy2) n2++;
      tick();
    end
    wren = 1'b0;
    rd_en = 1'b0;
    $display("[%0t] clear sweep lasted %0d/%0d cycles", $time, n1, n2);
  endtask

  int nb1, nb2;

  initial begin
    rst = 1'b1; clear = 1'b0; wren = 1'b0; rd_en = 1'b0;
    wraddr = '0; rdaddr = '0; wrdata = '0;
    issue_v = 1'b0; issue_d = '0; p1v = 1'b0; p1d = '0; p2v = 2'b00;
    p2d[0] = '0; p2d[1] = '0; eq1 = '0; eq2 = '0;

    // Reset values, then the post-reset clear sweep.
    tick();
    tick();
    check("busy_in_reset_lat1", 64'(busy1), 64'(1));
    check("busy_in_reset_lat2", 64'(busy2), 64'(1));
    rst = 1'b0;
    busy_run(nb1, nb2);
    check("reset_clear_len_lat1", 64'(nb1), 64'(16));
    check("reset_clear_len_lat2", 64'(nb2), 64'(16));

    // Every address reads back the clear value.
    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), 36'h0);
      tick();
      tick();
    end

    // Write then read next cycle.
    wr(4'd5, 36'h123456789);
    rd(4'd5, 36'h123456789);
    tick();
    tick();

    // Same-cycle write/read forwarding; following write must not leak in.
    wr(4'd7, 36'h111);
    $display("[%0t] write+read addr=7 data=abc expect=abc", $time);
    wren = 1'b1; wraddr = 4'd7; wrdata = 36'hABC;
    rd_en = 1'b1; rdaddr = 4'd7; issue_v = 1'b1; issue_d = 36'hABC;
    tick();
    rd_en = 1'b0;
    wr(4'd7, 36'hDEF);
    tick();
    rd(4'd7, 36'hDEF);
    tick();
    tick();

    // Fill, then 16 back-to-back reads.
    for (int a = 0; a < 16; a++) begin
      wr(AW'(a), 36'h800000000 | (36'(a) * 36'h001010101));
    end
    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), 36'h800000000 | (36'(a) * 36'h001010101));
    end
    tick();
    tick();

    // Clear request together with a read and a write.
    wr(4'd3, 36'h55);
    $display("[%0t] clear + read addr=3 expect=55 + write addr=9", $time);
    clear = 1'b1;
    wren = 1'b1; wraddr = 4'd9; wrdata = 36'h77;
    rd_en = 1'b1; rdaddr = 4'd3; issue_v = 1'b1; issue_d = 36'h55;
    tick();
    clear = 1'b0; wren = 1'b0; rd_en = 1'b0;
    check("busy_after_clear_lat1", 64'(busy1), 64'(1));
    check("busy_after_clear_lat2", 64'(busy2), 64'(1));
    busy_run(nb1, nb2);
    check("req_clear_len_lat1", 64'(nb1), 64'(16));
    check("req_clear_len_lat2", 64'(nb2), 64'(16));
    rd(4'd3, 36'h0);
    rd(4'd9, 36'h0);
    rd(4'd5, 36'h0);
    tick();
    tick();

    // Reset right after a read: lat2 result is dropped.
    wr(4'd5, 36'h5A5);
    rd(4'd5, 36'h5A5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_run(nb1, nb2);
    check("rst_inflight_clear_len_lat1", 64'(nb1), 64'(16));
    check("rst_inflight_clear_len_lat2", 64'(nb2), 64'(16));

    // Reset at clear counter value 9 restarts a full sweep.
    wr(4'd3, 36'h66);
    $display("[%0t] clear request, reset at counter 9", $time);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1;
    tick();
    check("busy_mid_reset_lat1", 64'(busy1), 64'(1));
    check("busy_mid_reset_lat2", 64'(busy2), 64'(1));
    rst = 1'b0;
    busy_run(nb1, nb2);
    check("restart_clear_len_lat1", 64'(nb1), 64'(16));
    check("restart_clear_len_lat2", 64'(nb2), 64'(16));
    rd(4'd3, 36'h0);
    rd(4'd5, 36'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_memory_pipe.md
# edge_memory_pipe

Parametrised simple-dual-port edge storage for the graph pipeline and the successor to the single-cycle edge store. It adds a configurable read latency with a valid strobe, write-to-read forwarding on same-address collisions, and a hardware clear sequencer that zeroes the array after reset or on request. Producers use the write port to fill edge lists. Traversal logic issues reads and consumes `q` on `q_valid`.

## Interface
- `ADDR_W`, 10, address width; depth = 2^ADDR_W words
- `DATA_W`, 36, word width
- `RD_LAT`, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)
- `CLEAR_ON_RESET`, 1, 1 = run the clear sequence after every reset
- `CLEAR_VAL`, 0, word value written by the clear sequence (DATA_W bits)

- `clk` input 1: single clock for all logic.
- `rst` input 1: reset, synchronous, active-high.
- `clear` input 1: single-cycle request to clear the whole array.
- `busy` output 1: high while the clear sequence runs.
- `wraddr` input ADDR_W: write address.
- `wren` input 1: write enable.
- `wrdata` input DATA_W: write data.
- `rdaddr` input ADDR_W: read address.
- `rd_en` input 1: read request.
- `q` output DATA_W: read data.
- `q_valid` output 1: `q` is valid this cycle.

## Operation
- FSM has two states, IDLE and CLEAR.
  - On reset: the FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - IDLE→CLEAR: `clear`=1 in IDLE.
  - CLEAR→IDLE: after the last address is written.
- CLEAR behaviour:
  - An internal counter runs 0..2^ADDR_W−1 and writes CLEAR_VAL to one address per cycle.
  - `busy`=1 throughout.
  - External `wren` and `rd_en` are ignored; no `q_valid` is generated for them.
  - `clear` asserted while already in CLEAR is ignored; the counter does not restart.
- IDLE behaviour:
  - `wren` writes `wrdata` to `wraddr`.
  - `rd_en` reads `rdaddr`.
- Forwarding: a read returns array contents including any write in the same cycle as `rd_en`.
  - When `wren` && `rd_en` && `wraddr==rdaddr`, `q` = that cycle's `wrdata`.
  - Writes after the read cycle never alter an in-flight result.
- `clear` and `wren` in the same IDLE cycle: the write executes, then the clear overwrites it.
- `clear` and `rd_en` in the same IDLE cycle: the read is accepted and completes with pre-clear data.
- Reads accepted before CLEAR is entered always complete normally.
- Reset mid-clear: the counter returns to 0.
  - CLEAR_ON_RESET=1: the sequence restarts.
  - CLEAR_ON_RESET=0: the FSM goes to IDLE and the array contents are unspecified.
- Reset drops any in-flight read; no `q_valid` is produced for it.

## Timing
- Reset values of outputs: `q`=0, `q_valid`=0, `busy`=CLEAR_ON_RESET.
- Read latency: `rd_en` accepted in cycle t gives `q_valid`=1 and `q` valid in cycle t+RD_LAT, for exactly one cycle per request.
- Full-rate reads: back-to-back reads are accepted every cycle, with no bubbles in IDLE.
- `q` holds its last value when `q_valid`=0.
- Clear after reset: the first cycle with `rst`=0 writes address 0. `busy` stays high for exactly 2^ADDR_W cycles after `rst` deasserts.
- Clear on request: `clear` in cycle t gives `busy`=1 in cycles t+1..t+2^ADDR_W, address k is written in cycle t+1+k, and `busy`=0 from t+2^ADDR_W+1.
- A read issued in the first IDLE cycle after clear returns CLEAR_VAL for any address.
- Counter width is ADDR_W+1, or ADDR_W with a terminal-count flag; no wrap-around re-clear.

## Structure
- Shared package `edge_mem_pkg` holds:
  - the RD_LAT legal-value check
  - the FSM state encoding (IDLE, CLEAR)
  - the default CLEAR_VAL
- Sub-module `sdp_ram`:
  - inferred simple-dual-port array, read-first, 1-cycle registered read
  - parameters ADDR_W and DATA_W
  - contains no reset logic
- Top level contains:
  - the write-port mux between external writes and the clear counter
  - the forwarding compare and data register
  - the optional output stage
  - the `q_valid` shift register

## Test plan
- Reset release, CLEAR_ON_RESET=1, ADDR_W=4 → `busy` high for exactly 16 cycles. Then a read of each of addresses 0..15 returns 0, with `q_valid` RD_LAT cycles after each `rd_en`.
- Write 0x123456789 to address 5, then read address 5 in the next cycle → `q`=0x123456789, with `q_valid` at t+1 (RD_LAT=1) and at t+2 (RD_LAT=2).
- Same-cycle write 0xABC to address 7 and read of address 7, where the array previously held 0x111 → `q`=0xABC. A write of 0xDEF to address 7 in the following cycle does not change the result.
- Continuous reads of addresses 0..15 on consecutive cycles → 16 consecutive `q_valid` pulses carrying the matching data in order.
- `clear` pulsed with a read to address 3 (holding 0x55) in the same cycle → that read returns 0x55. The read sets `q_valid` while `busy` is already high. `wren`/`rd_en` during `busy` cause no writes and no `q_valid`. After `busy` falls, address 3 reads 0.
- `rst` asserted at clear counter value 9 → `busy` stays high. With CLEAR_ON_RESET=1, the sequence restarts at address 0 and runs a full 2^ADDR_W cycles. An in-flight read produces no `q_valid`.
